// File: rtl/memoria_pkg.sv
// Shared types and constants for the RTC/stopwatch register memory.
// Presets and the borrow reload switch to packed BCD when MEMORIA_BCD_EN is defined.
package memoria_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  localparam int STAT_EXP  = 0;
  localparam int STAT_RUN  = 1;
  localparam int STAT_ZERO = 2;

`ifdef MEMORIA_BCD_EN
  localparam int DEF_PRE_H  = 'h23;
  localparam int DEF_PRE_M  = 'h59;
  localparam int DEF_PRE_S  = 'h59;
  localparam int DEC_RELOAD = 'h59;
`else
  localparam int DEF_PRE_H  = 23;
  localparam int DEF_PRE_M  = 59;
  localparam int DEF_PRE_S  = 59;
  localparam int DEC_RELOAD = 59;
`endif

endpackage

// File: rtl/memoria_hms_decrement.sv
// Combinational h/m/s decrement with borrow; binary, or packed BCD under MEMORIA_BCD_EN.
// Latency: none (pure logic). Backpressure: none.
module hms_decrement
  import memoria_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] s_i,
  input  logic [DW-1:0] m_i,
  input  logic [DW-1:0] h_i,
  output logic [DW-1:0] s_o,
  output logic [DW-1:0] m_o,
  output logic [DW-1:0] h_o,
  output logic          is_zero_o
);

  localparam logic [DW-1:0] RELOAD = DW'(DEC_RELOAD);

  // Only ever applied to a non-zero field; a zero field takes the reload path instead.
  function automatic logic [DW-1:0] dec1(input logic [DW-1:0] v);
`ifdef MEMORIA_BCD_EN
    // Units at 0 borrow from tens: x0 -> (x-1)9, which is v - 7.
    if (v[3:0] == 4'd0) return v - DW'(7);
    return v - DW'(1);
`else
    return v - DW'(1);
`endif
  endfunction

  always_comb begin
    s_o = dec1(s_i);
    m_o = m_i;
    h_o = h_i;
    if (s_i == '0) begin
      s_o = RELOAD;
      if (m_i != '0) begin
        m_o = dec1(m_i);
      end else begin
        m_o = RELOAD;
        h_o = dec1(h_i);
      end
    end
    is_zero_o = (s_o == '0) && (m_o == '0) && (h_o == '0);
  end

endmodule

// File: rtl/memoria_timer_param.sv
// Register memory with countdown engine, status register and latched expiry irq (BCD via MEMORIA_BCD_EN).
// Latency: 1-cycle registered read (read-old); decrement/state change on the sampling edge. Backpressure: none.
module memoria_timer_param
  import memoria_pkg::*;
#(
  parameter int DW        = 8,
  parameter int AW        = 4,
  parameter int T_BASE    = 7,
  parameter int STAT_ADDR = 11,
  parameter int PRE_H     = DEF_PRE_H,
  parameter int PRE_M     = DEF_PRE_M,
  parameter int PRE_S     = DEF_PRE_S
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          irq_ack,
  output logic          irq
);

  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] A_S   = AW'(T_BASE);
  localparam logic [AW-1:0] A_M   = AW'(T_BASE + 1);
  localparam logic [AW-1:0] A_H   = AW'(T_BASE + 2);
  localparam logic [AW-1:0] A_ST  = AW'(STAT_ADDR);
  localparam logic [DW-1:0] P_S   = DW'(PRE_S);
  localparam logic [DW-1:0] P_M   = DW'(PRE_M);
  localparam logic [DW-1:0] P_H   = DW'(PRE_H);

  state_e        state_q, state_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] status;
  logic [DW-1:0] dec_s, dec_m, dec_h;
  logic          dec_zero;
  logic          zero, wr_timer, wr_w1c;

  assign zero     = (mem_q[A_S] == '0) && (mem_q[A_M] == '0) && (mem_q[A_H] == '0);
  assign wr_timer = wr_en && ((wr_addr == A_S) || (wr_addr == A_M) || (wr_addr == A_H));
  assign wr_w1c   = wr_en && (wr_addr == A_ST) && wr_data[0];

  hms_decrement #(.DW(DW)) u_dec (
    .s_i       (mem_q[A_S]),
    .m_i       (mem_q[A_M]),
    .h_i       (mem_q[A_H]),
    .s_o       (dec_s),
    .m_o       (dec_m),
    .h_o       (dec_h),
    .is_zero_o (dec_zero)
  );

  always_comb begin
    status            = '0;
    status[STAT_EXP]  = (state_q == EXPIRED);
    status[STAT_RUN]  = (state_q == RUN);
    status[STAT_ZERO] = zero;
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          if (zero) begin
            mem_d[A_S] = P_S;
            mem_d[A_M] = P_M;
            mem_d[A_H] = P_H;
          end
        end
      end
      RUN: begin
        // An empty timer stalls the engine rather than expiring; a host timer write eats the tick.
        if (stop) begin
          state_d = IDLE;
        end else if (tick && !wr_timer && !zero) begin
          mem_d[A_S] = dec_s;
          mem_d[A_M] = dec_m;
          mem_d[A_H] = dec_h;
          if (dec_zero) state_d = EXPIRED;
        end
      end
      EXPIRED: begin
        if (irq_ack || wr_w1c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wr_en && (wr_addr != A_ST)) mem_d[wr_addr] = wr_data;
  end

  always_comb begin
    rd_data_d = mem_q[rd_addr];
    if (rd_addr == A_ST) begin
      rd_data_d = status;
    end else if (zero && (state_q == IDLE)) begin
      if (rd_addr == A_S) rd_data_d = P_S;
      if (rd_addr == A_M) rd_data_d = P_M;
      if (rd_addr == A_H) rd_data_d = P_H;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      mem_q     <= mem_d;
    end
  end

  assign rd_data = rd_data_q;
  assign irq     = (state_q == EXPIRED);

endmodule
